porta_logica_pipeline: RTL and testbench

- Parametrised, pipelined successor to the single-bit two-input AND gate.
- Applies one of eight bitwise logic operations to two LARGURA-bit operands.
- Buffers operands and results in a two-stage valid/ready pipeline with full backpressure.
- Flags zero and all-ones results and counts completed results; it is the logic slice of the processor datapath.

---
 rtl/porta_logica_pipeline_if.sv | 26 ++
 rtl/porta_logica_pipeline.sv | 119 +++++++++++
 tb/tb_porta_logica_pipeline.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/porta_logica_pipeline_if.sv
// Operand/result handshake bundle for the pipelined logic slice.
// master = producer/consumer side, slave = the pipeline itself.
interface porta_logica_pipeline_if #(
    parameter int unsigned LARGURA = 8
);
    logic [LARGURA-1:0] Entrada1;
    logic [LARGURA-1:0] Entrada2;
    logic [2:0]         Operacao;
    logic               ValidoEntrada;
    logic               ProntoEntrada;
    logic [LARGURA-1:0] Saida;
    logic               ValidoSaida;
    logic               ProntoSaida;
    logic               Zero;
    logic               TodosUm;

    modport master (
        output Entrada1, Entrada2, Operacao, ValidoEntrada, ProntoSaida,
        input  ProntoEntrada, Saida, ValidoSaida, Zero, TodosUm
    );

    modport slave (
        input  Entrada1, Entrada2, Operacao, ValidoEntrada, ProntoSaida,
        output ProntoEntrada, Saida, ValidoSaida, Zero, TodosUm
    );
endinterface

// File: rtl/porta_logica_pipeline.sv
// Two-stage valid/ready logic slice: eight bitwise operations on LARGURA-bit operands,
// zero/all-ones flags and a count of consumed results.
module porta_logica_pipeline #(
    parameter int unsigned LARGURA      = 8,
    parameter int unsigned LARGURA_CONT = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    porta_logica_pipeline_if.slave  porta,
    output logic [LARGURA_CONT-1:0] Contador,
    input  logic                    LimparContador
);

    // Encoding is {v1, v2}: stage-1 valid, stage-2 valid.
    typedef enum logic [1:0] {
        VAZIO        = 2'b00,
        MEIO_SAIDA   = 2'b01,
        MEIO_CAPTURA = 2'b10,
        CHEIO        = 2'b11
    } estado_t;

    estado_t estado, proximo;

    logic               v1, v2;
    logic               pronto_entrada;
    logic               aceita, avanca, consome;
    logic               v1_prox, v2_prox;
    logic [LARGURA-1:0] a1, b1;
    logic [2:0]         op1;
    logic [LARGURA-1:0] resultado;
    logic [LARGURA-1:0] saida_r;
    logic               zero_r, todos_r;

    assign v1 = (estado == MEIO_CAPTURA) || (estado == CHEIO);
    assign v2 = (estado == MEIO_SAIDA)   || (estado == CHEIO);

    // Ready depends only on state and the consumer's ready, never on ValidoEntrada.
    assign pronto_entrada = !v1 || !v2 || porta.ProntoSaida;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado <= VAZIO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        aceita  = 1'b0;
        avanca  = 1'b0;
        consome = 1'b0;
        v1_prox = v1;
        v2_prox = v2;
        proximo = estado;

        aceita  = porta.ValidoEntrada && pronto_entrada;
        avanca  = v1 && (!v2 || porta.ProntoSaida);
        consome = v2 && porta.ProntoSaida;
        v1_prox = aceita || (v1 && !avanca);
        v2_prox = avanca || (v2 && !consome);
        proximo = estado_t'({v1_prox, v2_prox});
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a1  <= '0;
            b1  <= '0;
            op1 <= '0;
        end else if (aceita) begin
            a1  <= porta.Entrada1;
            b1  <= porta.Entrada2;
            op1 <= porta.Operacao;
        end
    end

    always_comb begin
        resultado = '0;
        case (op1)
            3'b000:  resultado = a1 & b1;
            3'b001:  resultado = a1 | b1;
            3'b010:  resultado = a1 ^ b1;
            3'b011:  resultado = ~(a1 & b1);
            3'b100:  resultado = ~(a1 | b1);
            3'b101:  resultado = ~(a1 ^ b1);
            3'b110:  resultado = ~a1;
            default: resultado = a1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            saida_r <= '0;
            zero_r  <= 1'b0;
            todos_r <= 1'b0;
        end else if (avanca) begin
            saida_r <= resultado;
            zero_r  <= (resultado == '0);
            todos_r <= (resultado == '1);
        end
    end

    // A clear in the same cycle as a consume takes priority.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Contador <= '0;
        end else if (LimparContador) begin
            Contador <= '0;
        end else if (consome) begin
            Contador <= Contador + 1'b1;
        end
    end

    assign porta.ProntoEntrada = pronto_entrada;
    assign porta.ValidoSaida   = v2;
    assign porta.Saida         = saida_r;
    assign porta.Zero          = zero_r;
    assign porta.TodosUm       = todos_r;

endmodule

// File: tb/tb_porta_logica_pipeline.sv
// Bench for porta_logica_pipeline: directed scenarios plus a randomized run against a queue model.
// A second instance with a 4-bit counter shares the same stimulus.
module tb_porta_logica_pipeline;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    porta_logica_pipeline_if #(.LARGURA(8)) bus ();
    porta_logica_pipeline_if #(.LARGURA(8)) bus4 ();

    logic [15:0] cont;
    logic [3:0]  cont4;
    logic        limpar;

    assign bus4.Entrada1      = bus.Entrada1;
    assign bus4.Entrada2      = bus.Entrada2;
    assign bus4.Operacao      = bus.Operacao;
    assign bus4.ValidoEntrada = bus.ValidoEntrada;
    assign bus4.ProntoSaida   = bus.ProntoSaida;

    porta_logica_pipeline #(.LARGURA(8), .LARGURA_CONT(16)) dut (
        .Clock(Clock), .Reset(Reset), .porta(bus),
        .Contador(cont), .LimparContador(limpar)
    );

    porta_logica_pipeline #(.LARGURA(8), .LARGURA_CONT(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .porta(bus4),
        .Contador(cont4), .LimparContador(limpar)
    );

    int compared   = 0;
    int mismatched = 0;

    // Outputs captured just before the edge that closes the current cycle.
    logic [7:0] sa_saida;
    logic       sa_valido, sa_zero, sa_todos, sa_pronto;

    function automatic logic [7:0] modelo(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        logic [7:0] base;
        case (op)
            3'd0, 3'd3: base = a & b;
            3'd1, 3'd4: base = a | b;
            3'd2, 3'd5: base = a ^ b;
            default:    base = a;
        endcase
        return (op inside {3'd3, 3'd4, 3'd5, 3'd6}) ? ~base : base;
    endfunction

    task automatic borda(output logic acc, output logic cons);
        @(negedge Clock);
        acc       = bus.ValidoEntrada && bus.ProntoEntrada;
        cons      = bus.ValidoSaida && bus.ProntoSaida;
        sa_saida  = bus.Saida;
        sa_valido = bus.ValidoSaida;
        sa_zero   = bus.Zero;
        sa_todos  = bus.TodosUm;
        sa_pronto = bus.ProntoEntrada;
        @(posedge Clock);
        #1;
    endtask

    task automatic pulso_limpar();
        logic acc, cons;
        limpar = 1'b1;
        borda(acc, cons);
        limpar = 1'b0;
    endtask

    task automatic test_reset();
        logic acc, cons;
        bit   visto;
        repeat (2) @(posedge Clock);
        #1;
        compared++; if (bus.ValidoSaida !== 1'b0) begin mismatched++; $display("FAIL reset_valido: got %b want 0", bus.ValidoSaida); end
        compared++; if (bus.Saida !== 8'h00) begin mismatched++; $display("FAIL reset_saida: got %h want 00", bus.Saida); end
        compared++; if (bus.Zero !== 1'b0 || bus.TodosUm !== 1'b0) begin mismatched++; $display("FAIL reset_flags: got %b%b want 00", bus.Zero, bus.TodosUm); end
        compared++; if (cont !== 16'd0 || cont4 !== 4'd0) begin mismatched++; $display("FAIL reset_contador: got %0d/%0d want 0/0", cont, cont4); end
        compared++; if (bus.ProntoEntrada !== 1'b1) begin mismatched++; $display("FAIL reset_pronto: got %b want 1", bus.ProntoEntrada); end
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;

        // one full transfer so the counter is non-zero before the mid-stream reset
        bus.Operacao = 3'b111; bus.Entrada1 = 8'h11; bus.ProntoSaida = 1'b1; bus.ValidoEntrada = 1'b1;
        borda(acc, cons);
        bus.ValidoEntrada = 1'b0;
        visto = 1'b0;
        for (int i = 0; i < 5 && !visto; i++) begin
            borda(acc, cons);
            if (cons) visto = 1'b1;
        end
        compared++; if (!visto || cont !== 16'd1) begin mismatched++; $display("FAIL reset_pre_contador: got %0d want 1", cont); end

        bus.ProntoSaida = 1'b0; bus.ValidoEntrada = 1'b1;
        bus.Entrada1 = 8'h21; borda(acc, cons);
        bus.Entrada1 = 8'h22; borda(acc, cons);
        bus.ValidoEntrada = 1'b0;
        #2 Reset = 1'b0;
        #1;
        compared++; if (bus.ValidoSaida !== 1'b0) begin mismatched++; $display("FAIL reset_meio_valido: got %b want 0", bus.ValidoSaida); end
        compared++; if (cont !== 16'd0) begin mismatched++; $display("FAIL reset_meio_contador: got %0d want 0", cont); end
        compared++; if (bus.ProntoEntrada !== 1'b1) begin mismatched++; $display("FAIL reset_meio_pronto: got %b want 1", bus.ProntoEntrada); end
        @(negedge Clock);
        Reset = 1'b1;
        bus.ProntoSaida = 1'b1;
        for (int i = 0; i < 6; i++) begin
            borda(acc, cons);
            compared++; if (sa_valido !== 1'b0) begin mismatched++; $display("FAIL reset_sem_resultado: cycle %0d got valido %b want 0", i, sa_valido); end
        end
    endtask

    task automatic test_all_ops();
        logic       acc, cons;
        logic [7:0] esperado [8];
        esperado = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h3C, 8'hC3};
        pulso_limpar();
        bus.Entrada1 = 8'hC3; bus.Entrada2 = 8'h5A; bus.ProntoSaida = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.ValidoEntrada = (i < 8);
            bus.Operacao = i[2:0];
            borda(acc, cons);
            if (i < 8) begin
                compared++; if (acc !== 1'b1) begin mismatched++; $display("FAIL ops_aceita: op %0d got %b want 1", i, acc); end
            end
            if (i >= 2) begin
                compared++; if (sa_valido !== 1'b1 || sa_saida !== esperado[i-2]) begin mismatched++; $display("FAIL ops_saida: op %0d got %b/%h want 1/%h", i-2, sa_valido, sa_saida, esperado[i-2]); end
            end else begin
                compared++; if (sa_valido !== 1'b0) begin mismatched++; $display("FAIL ops_latencia: cycle %0d got valido %b want 0", i, sa_valido); end
            end
        end
        bus.ValidoEntrada = 1'b0;
        compared++; if (cont !== 16'd8) begin mismatched++; $display("FAIL ops_contador: got %0d want 8", cont); end
    endtask

    task automatic test_flags();
        logic       acc, cons;
        logic [7:0] ea [2], eb [2], es [2];
        logic [2:0] eo [2];
        logic       ez [2], et [2];
        ea = '{8'h0F, 8'hAA}; eb = '{8'hF0, 8'hAA}; eo = '{3'b000, 3'b101};
        es = '{8'h00, 8'hFF}; ez = '{1'b1, 1'b0}; et = '{1'b0, 1'b1};
        for (int c = 0; c < 2; c++) begin
            bus.Entrada1 = ea[c]; bus.Entrada2 = eb[c]; bus.Operacao = eo[c];
            bus.ProntoSaida = 1'b0; bus.ValidoEntrada = 1'b1;
            borda(acc, cons);
            bus.ValidoEntrada = 1'b0;
            sa_valido = 1'b0;
            for (int i = 0; i < 5 && !sa_valido; i++) borda(acc, cons);
            compared++; if (sa_valido !== 1'b1 || sa_saida !== es[c]) begin mismatched++; $display("FAIL flags_saida: case %0d got %b/%h want 1/%h", c, sa_valido, sa_saida, es[c]); end
            compared++; if (sa_zero !== ez[c]) begin mismatched++; $display("FAIL flags_zero: case %0d got %b want %b", c, sa_zero, ez[c]); end
            compared++; if (sa_todos !== et[c]) begin mismatched++; $display("FAIL flags_todosum: case %0d got %b want %b", c, sa_todos, et[c]); end
            bus.ProntoSaida = 1'b1;
            borda(acc, cons);
        end
    endtask

    task automatic test_backpressure();
        logic       acc, cons;
        logic [7:0] proximo_dado, retido;
        bit         tem_retido;
        logic [7:0] recebidos [$];
        proximo_dado = 8'd0; tem_retido = 1'b0; retido = '0;
        bus.ProntoSaida = 1'b0; bus.Operacao = 3'b111;
        for (int i = 0; i < 6; i++) begin
            bus.ValidoEntrada = (proximo_dado < 8'd3);
            bus.Entrada1 = proximo_dado;
            bus.Entrada2 = 8'($urandom);
            borda(acc, cons);
            if (acc) proximo_dado++;
            if (sa_valido) begin
                if (tem_retido) begin
                    compared++; if (sa_saida !== retido) begin mismatched++; $display("FAIL bp_estavel: got %h want %h", sa_saida, retido); end
                end else begin
                    retido = sa_saida; tem_retido = 1'b1;
                end
            end
        end
        compared++; if (proximo_dado !== 8'd2) begin mismatched++; $display("FAIL bp_aceitos: got %0d want 2", proximo_dado); end
        compared++; if (sa_pronto !== 1'b0) begin mismatched++; $display("FAIL bp_pronto: got %b want 0", sa_pronto); end
        compared++; if (retido !== 8'h00) begin mismatched++; $display("FAIL bp_primeiro: got %h want 00", retido); end
        bus.ProntoSaida = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.ValidoEntrada = (proximo_dado < 8'd3);
            bus.Entrada1 = proximo_dado;
            borda(acc, cons);
            if (acc) proximo_dado++;
            if (cons) recebidos.push_back(sa_saida);
        end
        bus.ValidoEntrada = 1'b0;
        compared++; if (recebidos.size() !== 3) begin mismatched++; $display("FAIL bp_quantidade: got %0d want 3", recebidos.size()); end
        for (int k = 0; k < 3 && k < recebidos.size(); k++) begin
            compared++; if (recebidos[k] !== 8'(k)) begin mismatched++; $display("FAIL bp_ordem: idx %0d got %h want %h", k, recebidos[k], 8'(k)); end
        end
    endtask

    task automatic test_random();
        logic       acc, cons;
        logic [7:0] fila [$];
        logic [7:0] esp, anterior;
        bit         parado;
        int         enviados, recebidos;
        pulso_limpar();
        enviados = 0; recebidos = 0; parado = 1'b0; anterior = '0;
        for (int ciclo = 0; ciclo < 20000 && recebidos < 1000; ciclo++) begin
            bus.ValidoEntrada = (enviados < 1000) && ($urandom_range(0, 3) != 0);
            bus.Entrada1 = 8'($urandom);
            bus.Entrada2 = 8'($urandom);
            bus.Operacao = 3'($urandom);
            bus.ProntoSaida = ($urandom_range(0, 3) != 0);
            borda(acc, cons);
            if (parado) begin
                compared++; if (sa_valido !== 1'b1 || sa_saida !== anterior) begin mismatched++; $display("FAIL rnd_estavel: got %b/%h want 1/%h", sa_valido, sa_saida, anterior); end
            end
            if (cons) begin
                recebidos++;
                if (fila.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL rnd_extra: got result %h want none", sa_saida);
                end else begin
                    esp = fila.pop_front();
                    compared++; if (sa_saida !== esp) begin mismatched++; $display("FAIL rnd_saida: #%0d got %h want %h", recebidos, sa_saida, esp); end
                    compared++; if (sa_zero !== (esp == 8'h00) || sa_todos !== (esp == 8'hFF)) begin mismatched++; $display("FAIL rnd_flags: #%0d got %b%b want %b%b", recebidos, sa_zero, sa_todos, esp == 8'h00, esp == 8'hFF); end
                end
            end
            if (acc) begin
                fila.push_back(modelo(bus.Entrada1, bus.Entrada2, bus.Operacao));
                enviados++;
            end
            parado = sa_valido && !bus.ProntoSaida;
            anterior = sa_saida;
        end
        bus.ValidoEntrada = 1'b0; bus.ProntoSaida = 1'b1;
        compared++; if (recebidos !== 1000) begin mismatched++; $display("FAIL rnd_recebidos: got %0d want 1000", recebidos); end
        compared++; if (cont !== 16'd1000) begin mismatched++; $display("FAIL rnd_contador: got %0d want 1000", cont); end
        compared++; if (cont4 !== 4'd8) begin mismatched++; $display("FAIL rnd_contador4: got %0d want 8", cont4); end
    endtask

    task automatic test_counter();
        logic acc, cons;
        pulso_limpar();
        bus.ProntoSaida = 1'b1; bus.Operacao = 3'b111; bus.Entrada1 = 8'h5C;
        for (int i = 0; i < 18; i++) begin
            bus.ValidoEntrada = (i < 16);
            borda(acc, cons);
        end
        compared++; if (cont4 !== 4'd0) begin mismatched++; $display("FAIL cont_volta: got %0d want 0", cont4); end
        compared++; if (cont !== 16'd16) begin mismatched++; $display("FAIL cont_16: got %0d want 16", cont); end
        bus.ValidoEntrada = 1'b1; bus.ProntoSaida = 1'b0;
        borda(acc, cons);
        bus.ValidoEntrada = 1'b0;
        sa_valido = 1'b0;
        for (int i = 0; i < 5 && !sa_valido; i++) borda(acc, cons);
        bus.ProntoSaida = 1'b1; limpar = 1'b1;
        borda(acc, cons);
        limpar = 1'b0;
        compared++; if (cons !== 1'b1) begin mismatched++; $display("FAIL cont_consumo: got %b want 1", cons); end
        compared++; if (cont !== 16'd0 || cont4 !== 4'd0) begin mismatched++; $display("FAIL cont_limpar: got %0d/%0d want 0/0", cont, cont4); end
    endtask

    initial begin
        limpar = 1'b0;
        bus.Entrada1 = '0; bus.Entrada2 = '0; bus.Operacao = '0;
        bus.ValidoEntrada = 1'b0; bus.ProntoSaida = 1'b0;
        test_reset();
        test_all_ops();
        test_flags();
        test_backpressure();
        test_random();
        test_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
